// File: rtl/hack_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hack_loader_pkg
// Brief    : Shared widths, limits and FSM state encoding for the boot loader.
// Revision : 1.0
// ============================================================================
package hack_loader_pkg;

  localparam int c_ADDR_W    = 15;
  localparam int c_DATA_W    = 16;
  localparam int c_BYTE_W    = 8;
  localparam int c_CSUM_W    = 8;
  localparam int c_MAX_WORDS = 16384;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CNT_LO = 3'd1,
    S_DAT_HI = 3'd2,
    S_DAT_LO = 3'd3,
    S_WRITE  = 3'd4,
    S_CHECK  = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

endpackage
`default_nettype wire

// File: rtl/hack_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : hack_loader_if
// Brief    : Byte-stream handshake plus RAM write bus of the boot loader.
// Revision : 1.0
// ============================================================================
interface hack_loader_if;
  import hack_loader_pkg::*;

  logic [c_BYTE_W-1:0] in_data;
  logic                in_valid;
  logic                in_ready;
  logic [c_ADDR_W-1:0] ram_address;
  logic [c_DATA_W-1:0] ram_data;
  logic                ram_we;

  // master: byte source and RAM observer; slave: the loader itself
  modport master (
    output in_data, in_valid,
    input  in_ready, ram_address, ram_data, ram_we
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, ram_address, ram_data, ram_we
  );

endinterface
`default_nettype wire

// File: rtl/hack_loader.sv
`default_nettype none
// ============================================================================
// Module   : hack_loader
// Brief    : Loads a counted, checksummed byte stream into program RAM while
//            holding the CPU in reset.
// Revision : 1.0
// ============================================================================
module hack_loader
  import hack_loader_pkg::*;
#(
  parameter int MAX_WORDS = c_MAX_WORDS
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  input  wire logic     clear,
  hack_loader_if.slave  bus,
  output logic          cpu_hold,
  output logic          done,
  output logic          err
);

  localparam logic [16:0] c_MAX = 17'(MAX_WORDS);

  state_t                r_state;
  state_t                w_next;
  logic [15:0]           r_count;
  logic [c_ADDR_W-1:0]   r_index;
  logic [c_CSUM_W-1:0]   r_sum;
  logic [c_BYTE_W-1:0]   r_hi;
  logic [c_ADDR_W-1:0]   r_ram_address;
  logic [c_DATA_W-1:0]   r_ram_data;

  logic                  w_in_ready;
  logic                  w_accept;
  logic [15:0]           w_count;
  logic [c_CSUM_W-1:0]   w_sum_next;
  logic                  w_last;

  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_count    = {r_count[15:8], bus.in_data};
  assign w_sum_next = r_sum + bus.in_data;
  assign w_last     = ({1'b0, r_index} == (r_count - 16'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (w_accept) w_next = S_CNT_LO;
      end
      S_CNT_LO: begin
        w_in_ready = 1'b1;
        if (w_accept) begin
          if ({1'b0, w_count} > c_MAX) w_next = S_ERR;
          else if (w_count == 16'd0)   w_next = S_CHECK;
          else                         w_next = S_DAT_HI;
        end
      end
      S_DAT_HI: begin
        w_in_ready = 1'b1;
        if (w_accept) w_next = S_DAT_LO;
      end
      S_DAT_LO: begin
        w_in_ready = 1'b1;
        if (w_accept) w_next = S_WRITE;
      end
      S_WRITE: w_next = w_last ? S_CHECK : S_DAT_HI;
      S_CHECK: begin
        w_in_ready = 1'b1;
        if (w_accept) w_next = (w_sum_next == '0) ? S_DONE : S_ERR;
      end
      S_DONE:  w_next = S_DONE;
      S_ERR:   w_next = S_ERR;
      default: w_next = S_IDLE;
    endcase
    if (clear) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count       <= '0;
      r_index       <= '0;
      r_sum         <= '0;
      r_hi          <= '0;
      r_ram_address <= '0;
      r_ram_data    <= '0;
    end else if (clear) begin
      r_count <= '0;
      r_index <= '0;
      r_sum   <= '0;
      r_hi    <= '0;
    end else begin
      if (w_accept) begin
        r_sum <= w_sum_next;
        case (r_state)
          S_IDLE:   r_count[15:8] <= bus.in_data;
          S_CNT_LO: r_count[7:0]  <= bus.in_data;
          S_DAT_HI: r_hi          <= bus.in_data;
          S_DAT_LO: begin
            r_ram_data    <= {r_hi, bus.in_data};
            r_ram_address <= r_index;
          end
          default: ;
        endcase
      end
      // Index stops on the last word so it never passes MAX_WORDS-1
      if (r_state == S_WRITE && !w_last) r_index <= r_index + 1'b1;
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.ram_we      = (r_state == S_WRITE);
  assign bus.ram_address = r_ram_address;
  assign bus.ram_data    = r_ram_data;
  assign cpu_hold        = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done            = (r_state == S_DONE);
  assign err             = (r_state == S_ERR);

endmodule
`default_nettype wire

// File: tb/tb_hack_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_hack_loader
// Brief    : Directed vector table plus hand sequences for the boot loader.
// Revision : 1.0
// ============================================================================
module tb_hack_loader;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;
  logic cpu_hold, done, err;

  hack_loader_if bus ();

  hack_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [79:0]      bytes;   // right-aligned, first byte most significant
    int               len;
    int               nw;      // expected writes, addresses 0..nw-1
    logic [3:0][15:0] wd;
    logic             exp_done;
    logic             exp_err;
  } vec_t;

  vec_t vecs [6];

  int n_cmp  = 0;
  int n_fail = 0;
  int n_acc  = 0;
  int n_overlap = 0;
  logic [14:0] wq_a [$];
  logic [15:0] wq_d [$];

  always @(negedge clk) begin
    if (bus.ram_we) begin
      wq_a.push_back(bus.ram_address);
      wq_d.push_back(bus.ram_data);
      if (bus.in_ready) n_overlap++;
    end
  end

  always @(posedge clk) begin
    if (rst_n && bus.in_valid && bus.in_ready) n_acc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at a falling edge after the transfer.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      check("ready_timeout", 32'(bus.in_ready), 32'd1);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    if (gap) begin
      bus.in_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic send_stream(input logic [79:0] bytes, input int len, input bit gap);
    for (int i = 0; i < len; i++) send_byte(bytes[8*(len-1-i) +: 8], gap);
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    wq_a.delete();
    wq_d.delete();
    n_acc = 0;
  endtask

  task automatic check_writes(input string tag, input int nw, input logic [3:0][15:0] wd);
    check({tag, "_nwrites"}, 32'(wq_a.size()), 32'(nw));
    for (int j = 0; j < nw && j < wq_a.size(); j++) begin
      check({tag, "_addr"}, 32'(wq_a[j]), 32'(j));
      check({tag, "_data"}, 32'(wq_d[j]), 32'(wd[j]));
    end
  endtask

  function automatic vec_t mk(input logic [79:0] b, input int len, input int nw,
                              input logic [3:0][15:0] wd, input logic d, input logic e);
    vec_t v;
    v.bytes = b; v.len = len; v.nw = nw; v.wd = wd; v.exp_done = d; v.exp_err = e;
    return v;
  endfunction

  initial begin
    vecs[0] = mk(80'h0002_1234_ABCD_40, 7, 2, {16'h0, 16'h0, 16'hABCD, 16'h1234}, 1'b1, 1'b0);
    vecs[1] = mk(80'h000000,             3, 0, '0,                                1'b1, 1'b0);
    vecs[2] = mk(80'h4001,               2, 0, '0,                                1'b0, 1'b1);
    vecs[3] = mk(80'h0001_0005_FF,       5, 1, {16'h0, 16'h0, 16'h0, 16'h0005},   1'b0, 1'b1);
    vecs[4] = mk(80'h0001_FFFF_01,       5, 1, {16'h0, 16'h0, 16'h0, 16'hFFFF},   1'b1, 1'b0);
    vecs[5] = mk(80'h0003_0001_0002_0003_F7, 9, 3,
                 {16'h0, 16'h0003, 16'h0002, 16'h0001}, 1'b1, 1'b0);

    rst_n = 1'b0; clear = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ram_we", 32'(bus.ram_we), 32'd0);
    check("rst_ram_addr", 32'(bus.ram_address), 32'd0);
    check("rst_ram_data", 32'(bus.ram_data), 32'd0);

    for (int v = 0; v < 6; v++) begin
      pulse_clear();
      send_stream(vecs[v].bytes, vecs[v].len, 1'b1);
      repeat (2) @(negedge clk);
      check_writes($sformatf("v%0d", v), vecs[v].nw, vecs[v].wd);
      check($sformatf("v%0d_done", v), 32'(done), 32'(vecs[v].exp_done));
      check($sformatf("v%0d_err", v), 32'(err), 32'(vecs[v].exp_err));
      check($sformatf("v%0d_hold", v), 32'(cpu_hold), 32'(vecs[v].exp_err));
      check($sformatf("v%0d_ready", v), 32'(bus.in_ready), 32'd0);
    end

    // Oversize: error is visible right after the second byte
    pulse_clear();
    send_byte(8'h40, 1'b0);
    send_byte(8'h01, 1'b0);
    bus.in_valid = 1'b0;
    check("ovr_err_now", 32'(err), 32'd1);
    check("ovr_ready", 32'(bus.in_ready), 32'd0);
    check("ovr_hold", 32'(cpu_hold), 32'd1);
    // Clear out of ERR
    pulse_clear();
    check("clr_err", 32'(err), 32'd0);
    check("clr_ready", 32'(bus.in_ready), 32'd1);
    check("clr_hold", 32'(cpu_hold), 32'd0);

    // count == MAX_WORDS is accepted
    send_byte(8'h40, 1'b0);
    send_byte(8'h00, 1'b0);
    bus.in_valid = 1'b0;
    check("max_err", 32'(err), 32'd0);
    check("max_ready", 32'(bus.in_ready), 32'd1);
    check("max_hold", 32'(cpu_hold), 32'd1);

    // Continuous in_valid: each byte once, nothing taken during WRITE
    pulse_clear();
    n_overlap = 0;
    send_stream(80'h0002_1234_ABCD_40, 7, 1'b0);
    repeat (2) @(negedge clk);
    check("cont_accepted", 32'(n_acc), 32'd7);
    check("cont_overlap", 32'(n_overlap), 32'd0);
    check_writes("cont", 2, {16'h0, 16'h0, 16'hABCD, 16'h1234});
    check("cont_done", 32'(done), 32'd1);

    // clear wins over a byte offered in the same cycle
    pulse_clear();
    bus.in_data = 8'h40; bus.in_valid = 1'b1; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; bus.in_valid = 1'b0;
    check("clrov_hold", 32'(cpu_hold), 32'd0);
    send_stream(80'h000000, 3, 1'b1);
    check("clrov_done", 32'(done), 32'd1);

    // Asynchronous reset mid-stream, then a full load
    pulse_clear();
    send_stream(80'h000212, 3, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_hold", 32'(cpu_hold), 32'd0);
    check("arst_ready", 32'(bus.in_ready), 32'd1);
    check("arst_addr", 32'(bus.ram_address), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    wq_a.delete(); wq_d.delete();
    send_stream(80'h0002_1234_ABCD_40, 7, 1'b1);
    repeat (2) @(negedge clk);
    check_writes("arst", 2, {16'h0, 16'h0, 16'hABCD, 16'h1234});
    check("arst_done", 32'(done), 32'd1);
    check("arst_err", 32'(err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
